// File: rtl/dmem_pkg.sv
// Shared types and sizing for the data-memory arbiter slice.
package dmem_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 128;

    // IDLE arbitrates requesters; CLEAR owns the memory for the zero-fill sweep.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } dmem_state_t;

    // One memory access as presented on the single memory port.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the parent owns last_grant.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // A lone requester wins outright; on contention the port that did not win last time wins.
    always_comb begin
        o_grant = 2'b00;
        if (i_valid == 2'b11) begin
            o_grant = i_last_grant ? 2'b01 : 2'b10;
        end else begin
            o_grant = i_valid;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU memory stage (port 0)
// and the debug/loader port (port 1), and owns the whole-memory zero-fill.
//
// Handshake: a requester raises rX_valid with addr/we/wdata and holds all of
// them stable until it sees rX_ready high in the same cycle; that cycle is the
// transfer. Writes land at the closing clock edge. Reads return rX_rvalid as a
// single-cycle pulse one cycle after the transfer, with rX_rdata holding the
// word until the next read response on that port.
module dmem_arbiter
#(
    parameter int ADDR_W = dmem_pkg::ADDR_W,
    parameter int DATA_W = dmem_pkg::DATA_W,
    parameter int DEPTH  = dmem_pkg::DEPTH
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_start,
    output logic              clear_busy,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r0_we,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic              r1_we,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              o_dbg_state
);

    import dmem_pkg::*;

    // The sweep counter carries one extra bit so the terminal compare never
    // relies on the address wrapping back to zero.
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

    dmem_state_t       r_state;
    dmem_state_t       w_state_nxt;
    logic [ADDR_W:0]   r_clr_cnt;
    logic [ADDR_W:0]   w_clr_cnt_nxt;
    logic              r_last_grant;

    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic [1:0]        w_valid;
    logic [1:0]        w_arb_grant;
    logic [1:0]        w_grant;
    logic              w_rd_acc0;
    logic              w_rd_acc1;
    mem_req_t          w_req0;
    mem_req_t          w_req1;
    mem_req_t          w_mem_req;

    assign w_valid = {r1_valid, r0_valid};
    assign w_req0  = '{addr: r0_addr, we: r0_we, wdata: r0_wdata};
    assign w_req1  = '{addr: r1_addr, we: r1_we, wdata: r1_wdata};

    rr_arb2 u_arb (
        .i_valid      (w_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant)
    );

    // State and sweep-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Next state, grant gating and memory-port mux.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_grant       = 2'b00;
        w_mem_req     = '0;
        clear_busy    = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant = w_arb_grant;
                if (w_grant[0]) begin
                    w_mem_req = w_req0;
                end else if (w_grant[1]) begin
                    w_mem_req = w_req1;
                end
                // A request granted alongside clear_start still completes this cycle.
                if (clear_start) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                clear_busy      = 1'b1;
                w_mem_req.addr  = r_clr_cnt[ADDR_W-1:0];
                w_mem_req.we    = 1'b1;
                w_mem_req.wdata = '0;
                if (r_clr_cnt == CLR_LAST) begin
                    w_state_nxt   = IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    // Round-robin history advances only when a request is actually accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (|w_grant) begin
            r_last_grant <= w_grant[1];
        end
    end

    assign w_rd_acc0 = w_grant[0] & ~r0_we;
    assign w_rd_acc1 = w_grant[1] & ~r1_we;

    // Read responses: one-cycle valid pulse, data held until the next response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_rd_acc0;
            r_rvalid1 <= w_rd_acc1;
            if (w_rd_acc0) begin
                r_rdata0 <= mem_rdata;
            end
            if (w_rd_acc1) begin
                r_rdata1 <= mem_rdata;
            end
        end
    end

    assign r0_ready    = w_grant[0];
    assign r1_ready    = w_grant[1];
    assign r0_rvalid   = r_rvalid0;
    assign r1_rvalid   = r_rvalid1;
    assign r0_rdata    = r_rdata0;
    assign r1_rdata    = r_rdata1;
    assign mem_addr    = w_mem_req.addr;
    assign mem_we      = w_mem_req.we;
    assign mem_wdata   = w_mem_req.wdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, reference model, directed and random traffic.
module tb_dmem_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int DEPTH = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          clear_start = 1'b0;
  logic          clear_busy;
  logic          r0_valid = 1'b0, r1_valid = 1'b0;
  logic          r0_ready, r1_ready;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic          r0_we = 1'b0, r1_we = 1'b0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          dbg_state;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_we(r0_we),
    .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_we(r1_we),
    .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .o_dbg_state(dbg_state)
  );

  // Behavioural single-port memory: combinational read, write at the clock edge.
  logic [DW-1:0] mem_arr [DEPTH];
  assign mem_rdata = mem_arr[mem_addr];
  always @(posedge clk) if (mem_we) mem_arr[mem_addr] <= mem_wdata;

  // ---------------- reference model ----------------
  logic [DW-1:0] gold [DEPTH];
  bit            m_clear;
  int            m_cnt;
  int            m_last;
  logic [DW-1:0] m_rd0, m_rd1;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic obs_busy, obs_rdy0, obs_rdy1;

  // ---------------- scoreboard check ----------------
  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of traffic: check combinational outputs mid-cycle, advance the
  // model, check registered outputs after the edge, then retire accepted requests.
  task automatic cycle();
    int            g;
    logic [AW-1:0] a;
    logic          we;
    logic [DW-1:0] wd;
    bit            nxt_rv0, nxt_rv1;
    g = -1;
    nxt_rv0 = 1'b0;
    nxt_rv1 = 1'b0;
    #1;
    obs_busy = clear_busy;
    obs_rdy0 = r0_ready;
    obs_rdy1 = r1_ready;
    if (reset) begin
      @(posedge clk); #1;
      m_clear = 1'b0;
      m_cnt = 0;
      m_last = 1;
      m_rd0 = '0;
      m_rd1 = '0;
      exp_q0.delete();
      exp_q1.delete();
      // Contents after a reset that may have cut a sweep short are whatever the memory holds.
      for (int i = 0; i < DEPTH; i++) gold[i] = mem_arr[i];
      check_eq("rst_rvalid0", r0_rvalid, 0);
      check_eq("rst_rvalid1", r1_rvalid, 0);
      check_eq("rst_rdata0", r0_rdata, 0);
      check_eq("rst_rdata1", r1_rdata, 0);
    end else begin
      check_eq("state", dbg_state, m_clear);
      if (m_clear) begin
        check_eq("clr_ready0", r0_ready, 0);
        check_eq("clr_ready1", r1_ready, 0);
        check_eq("clr_busy", clear_busy, 1);
        check_eq("clr_mem_we", mem_we, 1);
        check_eq("clr_mem_addr", mem_addr, m_cnt);
        check_eq("clr_mem_wdata", mem_wdata, 0);
        gold[m_cnt] = '0;
        if (m_cnt == DEPTH - 1) begin
          m_clear = 1'b0;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end else begin
        if (r0_valid && r1_valid) g = (m_last == 1) ? 0 : 1;
        else if (r0_valid) g = 0;
        else if (r1_valid) g = 1;
        check_eq("ready0", r0_ready, g == 0);
        check_eq("ready1", r1_ready, g == 1);
        check_eq("busy", clear_busy, 0);
        if (g < 0) begin
          check_eq("idle_mem_we", mem_we, 0);
          check_eq("idle_mem_addr", mem_addr, 0);
          check_eq("idle_mem_wdata", mem_wdata, 0);
        end else begin
          a  = (g == 0) ? r0_addr : r1_addr;
          we = (g == 0) ? r0_we : r1_we;
          wd = (g == 0) ? r0_wdata : r1_wdata;
          check_eq("mem_we", mem_we, we);
          check_eq("mem_addr", mem_addr, a);
          check_eq("mem_wdata", mem_wdata, wd);
          m_last = g;
          if (we) begin
            gold[a] = wd;
          end else if (g == 0) begin
            exp_q0.push_back(gold[a]);
            nxt_rv0 = 1'b1;
          end else begin
            exp_q1.push_back(gold[a]);
            nxt_rv1 = 1'b1;
          end
        end
        if (clear_start) m_clear = 1'b1;
      end
      @(posedge clk); #1;
      if (nxt_rv0) m_rd0 = exp_q0.pop_front();
      if (nxt_rv1) m_rd1 = exp_q1.pop_front();
      check_eq("rvalid0", r0_rvalid, nxt_rv0);
      check_eq("rvalid1", r1_rvalid, nxt_rv1);
      check_eq("rdata0", r0_rdata, m_rd0);
      check_eq("rdata1", r1_rdata, m_rd1);
    end
    if (obs_rdy0) r0_valid = 1'b0;
    if (obs_rdy1) r1_valid = 1'b0;
    clear_start = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic req0(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
    r0_valid = 1'b1; r0_addr = a; r0_we = we; r0_wdata = wd;
  endtask

  task automatic req1(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
    r1_valid = 1'b1; r1_addr = a; r1_we = we; r1_wdata = wd;
  endtask

  task automatic do_reset();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((r0_valid || r1_valid) && k < 50) begin
      cycle();
      k++;
    end
    check_eq({tag, "_drain"}, r0_valid || r1_valid, 0);
    cycle();
  endtask

  // Counts busy cycles of a sweep; optionally re-pulses clear_start partway through.
  task automatic run_clear(input int restart_at, output int n);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (n == restart_at) clear_start = 1'b1;
      cycle();
      if (obs_busy) n++;
      else break;
    end
  endtask

  task automatic gen_random();
    if (!r0_valid && $urandom_range(0, 99) < 60)
      req0(AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);
    if (!r1_valid && $urandom_range(0, 99) < 60)
      req1(AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] v;
      v = $urandom;
      mem_arr[i] = v;
      gold[i] = v;
    end
    m_clear = 1'b0; m_cnt = 0; m_last = 1; m_rd0 = '0; m_rd1 = '0;
    cycle();
    cycle();
    reset = 1'b0;

    // Write then read back on port 0.
    req0(7'd5, 1'b1, 32'hdeadbeef);
    cycle();
    check_eq("t1_wr_ready", obs_rdy0, 1);
    req0(7'd5, 1'b0, 32'h0);
    cycle();
    check_eq("t1_rd_ready", obs_rdy0, 1);
    check_eq("t1_rvalid", r0_rvalid, 1);
    check_eq("t1_rdata", r0_rdata, 32'hdeadbeef);
    cycle();
    check_eq("t1_rvalid_pulse", r0_rvalid, 0);

    // Sustained contention from reset: r0 first, then alternating.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!r0_valid) req0(7'd1, 1'b0, 32'h0);
      if (!r1_valid) req1(7'd2, 1'b0, 32'h0);
      cycle();
      check_eq("t2_grant_r0", obs_rdy0, (i % 2) == 0);
      check_eq("t2_grant_r1", obs_rdy1, (i % 2) == 1);
    end
    drain("t2");

    // Back-to-back r1 reads, then contention favours r0.
    for (int i = 0; i < 3; i++) begin
      req1(AW'(3 + i), 1'b0, 32'h0);
      cycle();
      check_eq("t3_r1_ready", obs_rdy1, 1);
    end
    req0(7'd10, 1'b0, 32'h0);
    req1(7'd11, 1'b0, 32'h0);
    cycle();
    check_eq("t3_contention_r0", obs_rdy0, 1);
    drain("t3");

    // Fill, sweep, read back zeros.
    req1(7'd0, 1'b1, 32'h11111111); drain("t4_w0");
    req1(7'd64, 1'b1, 32'h22222222); drain("t4_w64");
    req1(7'd127, 1'b1, 32'h33333333); drain("t4_w127");
    clear_start = 1'b1;
    cycle();
    run_clear(-1, n);
    check_eq("t4_busy_len", n, DEPTH);
    for (int i = 0; i < 3; i++) begin
      logic [AW-1:0] ra;
      ra = (i == 0) ? 7'd0 : (i == 1) ? 7'd64 : 7'd127;
      req0(ra, 1'b0, 32'h0);
      cycle();
      check_eq("t4_zero_rvalid", r0_rvalid, 1);
      check_eq("t4_zero_rdata", r0_rdata, 0);
    end

    // Write alongside clear_start, and a second clear_start mid-sweep.
    clear_start = 1'b1;
    req0(7'd9, 1'b1, 32'h12345678);
    cycle();
    check_eq("t5_wr_acc", obs_rdy0, 1);
    run_clear(10, n);
    check_eq("t5_busy_len", n, DEPTH);

    // Reset in the middle of a sweep.
    clear_start = 1'b1;
    cycle();
    for (int i = 0; i < 40; i++) cycle();
    do_reset();
    req0(7'd100, 1'b0, 32'h0);
    cycle();
    check_eq("t6_busy_after_rst", obs_busy, 0);
    check_eq("t6_ready_after_rst", obs_rdy0, 1);

    // Random traffic with occasional sweeps and resets.
    for (int i = 0; i < 2500; i++) begin
      gen_random();
      if ($urandom_range(0, 299) == 0) clear_start = 1'b1;
      if ($urandom_range(0, 699) == 0) do_reset();
      else cycle();
    end
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
